// File: rtl/snand_pll_ctrl_pkg.sv
// snand_pll_ctrl_pkg
//   Shared definitions for the PLL reset/lock sequencer: state encoding,
//   default parameter values, fixed status-counter widths and a counter
//   width helper.
package snand_pll_ctrl_pkg;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } pll_state_e;

  localparam int DEF_RST_HOLD_CYC     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_MAX_RETRIES      = 3;

  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  // Counter width for a count that runs 0..n-1. A parameter of 1 still
  // needs a 1-bit register, where $clog2 alone would give zero.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   1-bit two-flop synchronizer for asynchronous status inputs.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, both flops clear to 0
//     d     - asynchronous input
//     q     - synchronized output, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; the second gives it a full cycle to
  // resolve before anything downstream looks at the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snand_pll_ctrl.sv
// snand_pll_ctrl
//   PLL reset and lock sequencer. Holds the PLL in reset, waits for a
//   synchronized lock that stays high for LOCK_STABLE_CYC cycles, retries on
//   timeout, gives up after MAX_RETRIES, and re-sequences on lock loss or a
//   relock request. Runs entirely on the free-running reference clock.
//   Ports:
//     refclk       - PLL reference clock, the only clock
//     rst_n        - asynchronous active-low reset
//     pll_locked_i - raw PLL locked flag, asynchronous to refclk
//     relock_req_i - single-cycle pulse forcing a fresh sequence
//     pll_rst_o    - PLL reset, active-high (HOLD or FAIL)
//     sys_rst_n_o  - downstream reset, active-low (released in RUN)
//     ready_o      - clocks qualified (RUN)
//     fail_o       - retries exhausted (FAIL)
//     state_o      - current state encoding
//     retry_cnt_o  - timed-out attempts since last RUN or relock request
//     loss_cnt_o   - saturating count of lock losses seen in RUN
module snand_pll_ctrl
  import snand_pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked_i,
  input  logic                   relock_req_i,
  output logic                   pll_rst_o,
  output logic                   sys_rst_n_o,
  output logic                   ready_o,
  output logic                   fail_o,
  output logic [2:0]             state_o,
  output logic [RETRY_CNT_W-1:0] retry_cnt_o,
  output logic [LOSS_CNT_W-1:0]  loss_cnt_o
);

  localparam int HOLD_W = cnt_w(RST_HOLD_CYC);
  localparam int TMO_W  = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int STB_W  = cnt_w(LOCK_STABLE_CYC);

  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STB_W-1:0]       STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);

  pll_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [TMO_W-1:0]       tmo_cnt_q;
  logic [STB_W-1:0]       stb_cnt_q;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d, retry_inc;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   lock_s;
  logic                   in_lock_wait_q, in_lock_wait_d, timeout;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked_i),
    .q     (lock_s)
  );

  // The timeout window spans WAIT and STABLE together, so bouncing between
  // them on a glitchy lock does not buy extra time.
  assign in_lock_wait_q = (state_q == ST_WAIT) || (state_q == ST_STABLE);
  assign in_lock_wait_d = (state_d == ST_WAIT) || (state_d == ST_STABLE);
  assign timeout        = in_lock_wait_q && (tmo_cnt_q == TMO_LAST);
  assign retry_inc      = retry_q + RETRY_CNT_W'(1);

  // Next-state and status-counter logic. A relock request outranks a
  // timeout, which outranks any lock-driven move, so a relock landing on the
  // timeout cycle leaves retry_cnt cleared rather than incremented.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (relock_req_i && (state_q != ST_HOLD)) begin
      state_d = ST_HOLD;
      retry_d = '0;
    end else if (timeout) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) state_d = ST_STABLE;
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_HOLD;
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // State, counters and registered output decodes. Each phase counter only
  // advances while the state stays in its phase and restarts from zero on
  // any entry, which is what makes a STABLE glitch restart qualification.
  // Outputs decode state_d so they switch on the same edge as state_o.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_o   <= 1'b1;
      sys_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      hold_cnt_q  <= ((state_q == ST_HOLD) && (state_d == ST_HOLD)) ?
                     hold_cnt_q + HOLD_W'(1) : '0;
      tmo_cnt_q   <= (in_lock_wait_q && in_lock_wait_d) ?
                     tmo_cnt_q + TMO_W'(1) : '0;
      stb_cnt_q   <= ((state_q == ST_STABLE) && (state_d == ST_STABLE)) ?
                     stb_cnt_q + STB_W'(1) : '0;
      pll_rst_o   <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
      sys_rst_n_o <= (state_d == ST_RUN);
      ready_o     <= (state_d == ST_RUN);
      fail_o      <= (state_d == ST_FAIL);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule
